writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Register-file write side of the Y86-64 datapath; it complements the decode stage's read-port logic.
- Accepts one retiring instruction per handshake from the memory stage, carrying icode, status, dstE/dstM and valE/valM.
- Serialises the E and M results onto a single register-file write port, in the order E then M.
- Tracks processor status, halts on any non-AOK status, and counts retired instructions.

Parameters:
DATA_W, 64, register data width
RID_W, 4, register index width; index 4'hf means "no register"
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  asynchronous active-low reset
in_valid_i  input  1  memory stage presents an instruction
in_ready_o  output  1  stage can accept this cycle
icode_i  input  4  instruction code (for trace only, no functional effect)
stat_i  input  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS
dstE_i  input  RID_W  E destination, 4'hf = none
dstM_i  input  RID_W  M destination, 4'hf = none
valE_i  input  DATA_W  ALU result
valM_i  input  DATA_W  memory read result
rf_we_o  output  1  register-file write enable
rf_waddr_o  output  RID_W  write index (0..14 only when rf_we_o=1)
rf_wdata_o  output  DATA_W  write data
retired_o  output  1  one-cycle pulse when an AOK instruction completes
stat_o  output  3  current processor status
halted_o  output  1  stage has stopped on a non-AOK status
retire_cnt_o  output  CNT_W  count of AOK instructions retired

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE and all input latches cleared. Outputs: rf_we_o=0, rf_waddr_o=4'hf, rf_wdata_o=0, retired_o=0, stat_o=3'h1, halted_o=0, retire_cnt_o=0. Outputs derive from registered state, so rf_we_o drops in the same instant reset asserts. Any pending write is discarded.
- Handshake: transfer occurs on a rising edge with in_valid_i=1 and in_ready_o=1. All inputs are latched at that edge. While in_ready_o=0, inputs are ignored.
- States:
  - IDLE
  - WR_E: write addr=dstE, data=valE
  - WR_M: write addr=dstM, data=valM
  - NOWR: single cycle, no write
  - HALTED
- Dispatch after acceptance, evaluated on the latched fields:
  - stat!=AOK -> NOWR (flagged as halting).
  - dstE!=F -> WR_E.
  - dstE==F and dstM!=F -> WR_M.
  - Both F -> NOWR.
- Write cycles:
  - WR_E: rf_we_o=1. Next state is WR_M if dstM!=F, else this is the last cycle.
  - WR_M: rf_we_o=1. Always the last cycle.
- Duplicate destination: if dstE==dstM, both writes occur, E first then M, so valM is the final value (popq %rsp semantics).
- Latency: the instruction occupies max(1, number of valid destinations) cycles after the accept edge.
- Last busy cycle, AOK instruction:
  - retired_o=1.
  - retire_cnt_o increments at the closing edge; it wraps modulo 2^CNT_W.
- Ready rule: in_ready_o=1 in IDLE, and also in the last busy cycle of an AOK instruction. This allows back-to-back accepts of one-write instructions at 1 per cycle. Otherwise in_ready_o=0.
- Non-AOK status (HLT, ADR, INS) in the NOWR cycle:
  - No write and retired_o=0.
  - stat_o takes the latched stat at the closing edge; state -> HALTED.
  - HALT retires nothing.
- HALTED:
  - in_ready_o=0, rf_we_o=0, halted_o=1, stat_o held.
  - Exits only via reset.
- stat_o remains 1 while all instructions are AOK.
- Illegal state encoding recovers to IDLE on the next edge with no write.

Test Plan:
- irmovq: stat=1, dstE=3, valE=0x1234, dstM=F -> one cycle with we=1, addr=3, data=0x1234; retired_o=1; count 0->1.
- popq %rsp: dstE=4, valE=0x100, dstM=4, valM=0xAB -> cycle1 addr4/0x100, cycle2 addr4/0xAB; ready=0 in cycle1 and 1 in cycle2; retired_o only in cycle2; count+1.
- nop: dstE=dstM=F, stat=1 -> one cycle with we=0, retired_o=1, count+1.
- Back-to-back: in_valid_i held for 3 irmovq (dstE=1,2,3, valE=0xA,0xB,0xC) -> writes on 3 consecutive cycles; ready stays 1; count=3.
- Fault: stat=3 (ADR), dstM=2 -> no write ever; halted_o=1 and stat_o=3 one cycle after acceptance; ready=0; later valid inputs ignored; count unchanged.
- Reset mid-op: assert rst_n_i=0 during the WR_E cycle of a popq -> rf_we_o=0 immediately; after release: IDLE, stat_o=1, count=0, no WR_M write.

Source files
------------

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: serialises E then M results onto one register-file write port,
// tracks processor status and counts retired instructions.
module writeback_stage #(
    parameter int DATA_W = 64,
    parameter int RID_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        icode_i,
    input  logic [2:0]        stat_i,
    input  logic [RID_W-1:0]  dstE_i,
    input  logic [RID_W-1:0]  dstM_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valM_i,
    output logic              rf_we_o,
    output logic [RID_W-1:0]  rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              retired_o,
    output logic [2:0]        stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);
    localparam logic [RID_W-1:0] RNONE = '1;
    localparam logic [2:0]       SAOK  = 3'h1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_E   = 3'd1,
        WR_M   = 3'd2,
        NOWR   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t            state;
    logic [3:0]        icode_q;
    logic [2:0]        stat_q;
    logic [RID_W-1:0]  dste_q, dstm_q;
    logic [DATA_W-1:0] vale_q, valm_q;
    logic [2:0]        stat_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              last, accept;

    // icode is carried only so a trace probe can see it
    logic unused_icode;
    assign unused_icode = ^icode_q;

    function automatic state_t dispatch(input logic [2:0] st,
                                        input logic [RID_W-1:0] de,
                                        input logic [RID_W-1:0] dm);
        if (st != SAOK)      return NOWR;
        else if (de != RNONE) return WR_E;
        else if (dm != RNONE) return WR_M;
        else                  return NOWR;
    endfunction

    always_comb begin
        last        = (state == WR_E && dstm_q == RNONE) || state == WR_M || state == NOWR;
        retired_o   = last && stat_q == SAOK;
        in_ready_o  = state == IDLE || retired_o;
        accept      = in_valid_i && in_ready_o;
        rf_we_o     = state == WR_E || state == WR_M;
        rf_waddr_o  = RNONE;
        rf_wdata_o  = '0;
        if (state == WR_E) begin
            rf_waddr_o = dste_q;
            rf_wdata_o = vale_q;
        end else if (state == WR_M) begin
            rf_waddr_o = dstm_q;
            rf_wdata_o = valm_q;
        end
        halted_o     = state == HALTED;
        stat_o       = stat_r;
        retire_cnt_o = cnt_r;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            icode_q <= '0;
            stat_q  <= '0;
            dste_q  <= '0;
            dstm_q  <= '0;
            vale_q  <= '0;
            valm_q  <= '0;
            stat_r  <= SAOK;
            cnt_r   <= '0;
        end else begin
            if (accept) begin
                icode_q <= icode_i;
                stat_q  <= stat_i;
                dste_q  <= dstE_i;
                dstm_q  <= dstM_i;
                vale_q  <= valE_i;
                valm_q  <= valM_i;
            end
            if (retired_o) cnt_r <= cnt_r + 1'b1;
            case (state)
                IDLE:   if (accept) state <= dispatch(stat_i, dstE_i, dstM_i);
                WR_E: begin
                    if (dstm_q != RNONE) state <= WR_M;
                    else if (accept)     state <= dispatch(stat_i, dstE_i, dstM_i);
                    else                 state <= IDLE;
                end
                WR_M:   state <= accept ? dispatch(stat_i, dstE_i, dstM_i) : IDLE;
                NOWR: begin
                    if (stat_q == SAOK) begin
                        state <= accept ? dispatch(stat_i, dstE_i, dstM_i) : IDLE;
                    end else begin
                        stat_r <= stat_q;
                        state  <= HALTED;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; expected register writes are queued at drive time
// and popped by a monitor whenever the write port fires.
module tb_writeback_stage;
    localparam int DATA_W = 64;
    localparam int RID_W  = 4;
    localparam int CNT_W  = 32;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        icode_i;
    logic [2:0]        stat_i;
    logic [RID_W-1:0]  dstE_i, dstM_i;
    logic [DATA_W-1:0] valE_i, valM_i;
    logic              rf_we_o;
    logic [RID_W-1:0]  rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic              retired_o;
    logic [2:0]        stat_o;
    logic              halted_o;
    logic [CNT_W-1:0]  retire_cnt_o;

    writeback_stage #(.DATA_W(DATA_W), .RID_W(RID_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .icode_i(icode_i), .stat_i(stat_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i), .valE_i(valE_i), .valM_i(valM_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .retired_o(retired_o), .stat_o(stat_o), .halted_o(halted_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [RID_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] st, input logic [3:0] de, input logic [3:0] dm,
                        input logic [63:0] ve, input logic [63:0] vm);
        in_valid_i = 1'b1;
        icode_i    = 4'h3;
        stat_i     = st;
        dstE_i     = de;
        dstM_i     = dm;
        valE_i     = ve;
        valM_i     = vm;
    endtask

    task automatic push(input logic [3:0] a, input logic [63:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // write-port monitor
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && rf_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {60'h0, rf_waddr_o}, 64'hdead);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", {60'h0, rf_waddr_o}, {60'h0, w.addr});
                chk("wr_data", rf_wdata_o, w.data);
            end
        end
    end

    initial begin
        rst_n_i = 1'b0;
        in_valid_i = 1'b0;
        icode_i = '0; stat_i = 3'h1; dstE_i = 4'hf; dstM_i = 4'hf; valE_i = '0; valM_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_we", rf_we_o, 1'b0);
        chk("rst_waddr", rf_waddr_o, 4'hf);
        chk("rst_wdata", rf_wdata_o, 64'h0);
        chk("rst_retired", retired_o, 1'b0);
        chk("rst_stat", stat_o, 3'h1);
        chk("rst_halted", halted_o, 1'b0);
        chk("rst_cnt", retire_cnt_o, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", in_ready_o, 1'b1);

        // irmovq
        send(3'h1, 4'h3, 4'hf, 64'h1234, 64'h0); push(4'h3, 64'h1234);
        @(negedge clk_i);
        chk("irm_we", rf_we_o, 1'b1);
        chk("irm_retired", retired_o, 1'b1);
        chk("irm_ready", in_ready_o, 1'b1);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("irm_cnt", retire_cnt_o, 1);
        chk("irm_idle_we", rf_we_o, 1'b0);

        // popq %rsp: E then M to the same register
        send(3'h1, 4'h4, 4'h4, 64'h100, 64'hAB); push(4'h4, 64'h100); push(4'h4, 64'hAB);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("pop_c1_ready", in_ready_o, 1'b0);
        chk("pop_c1_retired", retired_o, 1'b0);
        @(negedge clk_i);
        chk("pop_c2_ready", in_ready_o, 1'b1);
        chk("pop_c2_retired", retired_o, 1'b1);
        chk("pop_c2_we", rf_we_o, 1'b1);
        @(negedge clk_i);
        chk("pop_cnt", retire_cnt_o, 2);

        // nop
        send(3'h1, 4'hf, 4'hf, 64'h5, 64'h6);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("nop_we", rf_we_o, 1'b0);
        chk("nop_retired", retired_o, 1'b1);
        @(negedge clk_i);
        chk("nop_cnt", retire_cnt_o, 3);

        // back-to-back irmovq
        send(3'h1, 4'h1, 4'hf, 64'hA, 64'h0); push(4'h1, 64'hA);
        @(negedge clk_i);
        chk("b2b_ready1", in_ready_o, 1'b1);
        send(3'h1, 4'h2, 4'hf, 64'hB, 64'h0); push(4'h2, 64'hB);
        @(negedge clk_i);
        chk("b2b_ready2", in_ready_o, 1'b1);
        chk("b2b_we2", rf_we_o, 1'b1);
        send(3'h1, 4'h3, 4'hf, 64'hC, 64'h0); push(4'h3, 64'hC);
        @(negedge clk_i);
        chk("b2b_ready3", in_ready_o, 1'b1);
        chk("b2b_we3", rf_we_o, 1'b1);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_cnt", retire_cnt_o, 6);
        chk("b2b_drained", exp_q.size(), 0);

        // reset during WR_E of a popq: the M write must never appear
        send(3'h1, 4'h4, 4'h4, 64'h100, 64'hAB);
        @(posedge clk_i);
        #1;
        chk("mid_we_before", rf_we_o, 1'b1);
        chk("mid_addr_before", rf_waddr_o, 4'h4);
        rst_n_i = 1'b0;
        #1;
        chk("mid_we_async", rf_we_o, 1'b0);
        chk("mid_addr_async", rf_waddr_o, 4'hf);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("mid_ready", in_ready_o, 1'b1);
        chk("mid_stat", stat_o, 3'h1);
        chk("mid_cnt", retire_cnt_o, 0);
        chk("mid_we_after", rf_we_o, 1'b0);

        // ADR fault: no writes, halt, later inputs ignored
        send(3'h3, 4'h1, 4'h2, 64'h11, 64'h22);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("adr_nowr_we", rf_we_o, 1'b0);
        chk("adr_nowr_retired", retired_o, 1'b0);
        chk("adr_nowr_ready", in_ready_o, 1'b0);
        @(negedge clk_i);
        chk("adr_halted", halted_o, 1'b1);
        chk("adr_stat", stat_o, 3'h3);
        chk("adr_ready", in_ready_o, 1'b0);
        send(3'h1, 4'h7, 4'hf, 64'h77, 64'h0);
        repeat (3) @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("halt_ready", in_ready_o, 1'b0);
        chk("halt_we", rf_we_o, 1'b0);
        chk("halt_stat", stat_o, 3'h3);
        chk("halt_cnt", retire_cnt_o, 0);
        chk("halt_still", halted_o, 1'b1);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
